regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x32 integer register file between
//  N_REQ write-back sources (ALU, LSU, CSR...), using round-robin arbitration
//  with valid/ready handshakes. It keeps a per-register pending-write
//  scoreboard so that issue can stall on RAW/WAW hazards.
//  Sits between the execute/memory units and the register file; drives its
//  wen/addr_in/din.
// PARAMETERS
//  N_REQ       2   number of write-back requesters (2..4)
//  ADDR_WIDTH  5   register index width (32 registers)
//  DATA_WIDTH  32  register data width
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  reset, synchronous, active-high
//  iss_valid   in   1                  issue stage presents instr writing iss_rd
//  iss_rd      in   ADDR_WIDTH         destination of issuing instr
//  iss_ready   out  1                  issue accepted this cycle
//  rs1, rs2    in   ADDR_WIDTH         source regs of issuing instr
//  rs1_busy    out  1                  rs1 has a pending write (comb)
//  rs2_busy    out  1                  rs2 has a pending write (comb)
//  req_valid   in   N_REQ              write-back request per source
//  req_rd      in   N_REQ*ADDR_WIDTH   dest reg per source, source i at [i*AW +: AW]
//  req_data    in   N_REQ*DATA_WIDTH   write data per source
//  req_ready   out  N_REQ              grant, one-hot or zero (comb)
//  rf_wen      out  1                  register file write enable (registered)
//  rf_waddr    out  ADDR_WIDTH         register file write address (registered)
//  rf_wdata    out  DATA_WIDTH         register file write data (registered)
//  pending     out  2**ADDR_WIDTH      scoreboard image, bit i = reg i pending
// BEHAVIOUR
//  Reset: pending=0, rf_wen=0, rf_waddr=0, rf_wdata=0, rr_ptr=0.
//   req_ready=0 while rst is high; iss_ready=0 while rst is high.
//  Arbitration (comb):
//   - Grant the first valid requester, searching from rr_ptr upward (mod N_REQ).
//   - Exactly one req_ready is high when any req_valid is high.
//   - A transfer fires when req_valid[i] & req_ready[i].
//   - rr_ptr <= granted index + 1 (mod N_REQ) on a transfer; otherwise it holds.
//  Write port, 1-cycle latency:
//   - The cycle after a transfer: rf_wen=1, rf_waddr=req_rd, rf_wdata=req_data.
//   - With no transfer, rf_wen=0 the next cycle.
//   - A transfer with rd==0 gets ready but produces rf_wen=0.
//  Sustained throughput: one write per cycle, with no bubble between back-to-back grants.
//  Scoreboard:
//   - Set pending[iss_rd] on iss_valid & iss_ready, if iss_rd != 0.
//   - Clear pending[rf_waddr] at the clock edge that ends a cycle with rf_wen=1.
//     This is the same edge at which the register file commits the data.
//   - pending[0] is always 0.
//   - rsN_busy = pending[rsN], OR (rf_wen & rf_waddr==rsN & rsN!=0), comb.
//     The second term covers the write that has not landed yet; rsN_busy is 0 for rsN==0.
//   - iss_ready = iss_valid & !rs1_busy & !rs2_busy & !pending[iss_rd] & !wb_inflight(iss_rd).
//     wb_inflight(r) = rf_wen & rf_waddr==r.
//     Net effect: at most one outstanding write per register, and no WAW.
//   - Set and clear of different registers in the same cycle: both take effect.
//     Set and clear of the same register cannot coincide, because iss_ready blocks it.
//  Protocol rules:
//   - A requester holds req_valid, req_rd and req_data stable until ready.
//   - A requester only writes registers it was issued for.
//   - A write to a non-pending register (protocol error) is still performed.
//     The scoreboard is unaffected, since clearing an already-clear bit is a no-op.
//  Reset mid-operation:
//   - An in-flight rf write is dropped: rf_wen=0 the cycle after rst.
//   - All pending bits clear, and the pointer returns to 0.
// STRUCTURE
//  Shared package wb_pkg holds:
//   - localparam REG_ZERO = 0
//   - typedef reg_idx_t (ADDR_WIDTH)
//   - typedef wb_req_t {rd, data}
//  Sub-module rr_arbiter (N-way round-robin: req, ptr -> one-hot gnt, gnt_idx).
//   It is reused later for the memory-bus arbiter.
//  Scoreboard and write-port registers live in this module.
// TESTING
//  1. rst high 2 cycles, then idle:
//     pending==0, rf_wen==0, req_ready==0 during rst.
//  2. Issue rd=5, then req0 {rd=5, data=0xDEADBEEF}:
//     - pending[5]=1 after issue.
//     - req_ready[0]=1 in the grant cycle.
//     - Next cycle: rf_wen=1, waddr=5, wdata=0xDEADBEEF.
//     - pending[5]=0 after that edge.
//  3. req0 and req1 valid for 4 cycles (rd=3, rd=4), rr_ptr=0:
//     - Grants are 0,1,0,1.
//     - rf_wen is high on 4 consecutive cycles.
//  4. Issue rd=7, then attempt issue with rs1=7 before write-back:
//     - iss_ready=0 and rs1_busy=1.
//     - In the rf_wen cycle for rd=7, rs1_busy stays 1.
//     - The cycle after, iss_ready=1.
//  5. Issue with iss_rd=0, then req1 {rd=0, data=0x1}:
//     - pending stays 0.
//     - req_ready[1]=1, and rf_wen=0 the next cycle.
//  6. Assert rst in the cycle after a grant (rf_wen due):
//     - rf_wen=0 next cycle.
//     - pending==0 and rr_ptr==0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared write-back types and helpers for the register-file write port and
// the arbiters built on rr_arbiter.
package wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  // x0 is hard-wired to zero: never tracked, never written.
  localparam int REG_ZERO = 0;

  typedef logic [WB_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [WB_DATA_WIDTH-1:0] reg_data_t;

  typedef struct packed {
    reg_idx_t  rd;
    reg_data_t data;
  } wb_req_t;

  // Round-robin successor of idx among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grants the first requester at or above ptr,
// wrapping modulo N. Purely combinational; the owner keeps the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  // cand[k] is the requester examined k-th when starting the search at ptr.
  logic [IW-1:0] cand [N];

  for (genvar k = 0; k < N; k++) begin : g_cand
    assign cand[k] = IW'((int'(ptr) + k) % N);
  end

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = |req;
    // Walk from the lowest priority upward; the last hit (highest priority) wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt          = '0;
        gnt[cand[k]] = 1'b1;
        gnt_idx      = cand[k];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among N_REQ write-back sources and keeps
// a per-register pending-write scoreboard for RAW/WAW issue stalls.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  output logic                        iss_ready,
  input  logic [ADDR_WIDTH-1:0]       rs1,
  input  logic [ADDR_WIDTH-1:0]       rs2,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_rd,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_waddr,
  output logic [DATA_WIDTH-1:0]       rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]    pending
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [IW-1:0]           rr_ptr;
  logic [N_REQ-1:0]        gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    gnt_valid;
  logic                    xfer;
  logic [ADDR_WIDTH-1:0]   sel_rd;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [2**ADDR_WIDTH-1:0] pending_next;
  logic                    iss_inflight;
  logic                    rs1_inflight;
  logic                    rs2_inflight;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = rst ? '0 : gnt;
  assign xfer      = !rst && gnt_valid;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A write sitting on the rf port has already left the scoreboard's view only
  // at the end of this cycle, so it must still block readers and re-issuers.
  assign iss_inflight = rf_wen && (rf_waddr == iss_rd);
  assign rs1_inflight = rf_wen && (rf_waddr == rs1);
  assign rs2_inflight = rf_wen && (rf_waddr == rs2);

  assign rs1_busy = (rs1 != ZERO_IDX) && (pending[rs1] || rs1_inflight);
  assign rs2_busy = (rs2 != ZERO_IDX) && (pending[rs2] || rs2_inflight);

  assign iss_ready = !rst && iss_valid && !rs1_busy && !rs2_busy &&
                     !pending[iss_rd] && !iss_inflight;

  always_comb begin
    pending_next = pending;
    if (rf_wen) begin
      pending_next[rf_waddr] = 1'b0;
    end
    if (iss_ready && (iss_rd != ZERO_IDX)) begin
      pending_next[iss_rd] = 1'b1;
    end
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the scoreboard is reset (unlike a data array) because stale
      // pending bits would stall issue forever after a mid-run reset.
      pending  <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
    end else begin
      pending <= pending_next;
      rf_wen  <= xfer && (sel_rd != ZERO_IDX);
      if (xfer) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
        rr_ptr   <= IW'(rr_next(int'(gnt_idx), N_REQ));
      end
    end
  end

endmodule
